// File: rtl/nn_pkg.sv
// Shared constants, index-width helper and FSM state type for the classifier datapath.
package nn_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_CLASSES = 10;
    localparam int NUM_IMAGES  = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CLASS_W = idx_width(NUM_CLASSES);
    localparam int IMAGE_W = idx_width(NUM_IMAGES);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/score_max_cmp.sv
// Combinational running-max step: signed greater-than and index select.
module score_max_cmp
    import nn_pkg::*;
#(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int IDX_W  = nn_pkg::CLASS_W
) (
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] cand,
    input  logic [IDX_W-1:0]  cand_idx,
    input  logic              first,
    output logic [DATA_W-1:0] next_max,
    output logic [IDX_W-1:0]  next_idx
);

    logic take;

    // Strict compare so a tie keeps the earlier (lower) class index.
    assign take     = first || ($signed(cand) > $signed(cur_max));
    assign next_max = take ? cand : cur_max;
    assign next_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/argmax_classifier.sv
// Streams NUM_CLASSES signed scores per image and emits the argmax class,
// winning score and image index through a valid/ready result port.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int DATA_W      = nn_pkg::DATA_W,
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int NUM_IMAGES  = nn_pkg::NUM_IMAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              score_valid,
    input  logic [DATA_W-1:0] score_data,
    output logic              score_ready,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [3:0]        result_class,
    output logic [DATA_W-1:0] result_score,
    output logic [3:0]        result_image,
    output logic              batch_done
);

    localparam int CW = idx_width(NUM_CLASSES);
    localparam int IW = idx_width(NUM_IMAGES);
    localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);
    localparam logic [IW-1:0] LAST_IMAGE = IW'(NUM_IMAGES - 1);

    state_t            state;
    logic [CW-1:0]     class_cnt;
    logic [IW-1:0]     image_cnt;
    logic [DATA_W-1:0] running_max_p0;
    logic [CW-1:0]     best_idx_p0;
    logic              batch_done_p0;

    logic [DATA_W-1:0] next_max;
    logic [CW-1:0]     next_idx;
    logic              score_xfer;
    logic              result_xfer;

    assign score_ready  = (state == ACCUM);
    assign result_valid = (state == EMIT);
    assign score_xfer   = score_valid && score_ready;
    assign result_xfer  = result_valid && result_ready;

    score_max_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (CW)
    ) u_cmp (
        .cur_max  (running_max_p0),
        .cur_idx  (best_idx_p0),
        .cand     (score_data),
        .cand_idx (class_cnt),
        .first    (class_cnt == '0),
        .next_max (next_max),
        .next_idx (next_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACCUM;
            class_cnt      <= '0;
            image_cnt      <= '0;
            running_max_p0 <= '0;
            best_idx_p0    <= '0;
            batch_done_p0  <= 1'b0;
        end else begin
            batch_done_p0 <= 1'b0;
            if (score_xfer) begin
                running_max_p0 <= next_max;
                best_idx_p0    <= next_idx;
                if (class_cnt == LAST_CLASS) begin
                    class_cnt <= '0;
                    state     <= EMIT;
                end else begin
                    class_cnt <= class_cnt + 1'b1;
                end
            end
            // Result handshake: release the FSM and advance the image index.
            if (result_xfer) begin
                state         <= ACCUM;
                batch_done_p0 <= (image_cnt == LAST_IMAGE);
                image_cnt     <= (image_cnt == LAST_IMAGE) ? '0 : image_cnt + 1'b1;
            end
        end
    end

    // Result fields are the registered max/index, held unchanged throughout EMIT.
    assign result_class = 4'(best_idx_p0);
    assign result_score = running_max_p0;
    assign result_image = 4'(image_cnt);
    assign batch_done   = batch_done_p0;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed cases plus randomized images.
module tb_argmax_classifier;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int NI = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          score_valid = 1'b0;
    logic [DW-1:0] score_data = '0;
    logic          score_ready;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [3:0]    result_class;
    logic [DW-1:0] result_score;
    logic [3:0]    result_image;
    logic          batch_done;

    argmax_classifier #(.DATA_W(DW), .NUM_CLASSES(NC), .NUM_IMAGES(NI)) dut (
        .clk          (clk),
        .reset        (reset),
        .score_valid  (score_valid),
        .score_data   (score_data),
        .score_ready  (score_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score),
        .result_image (result_image),
        .batch_done   (batch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    cls;
        logic [DW-1:0] score;
        logic [3:0]    img;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   model_img = 0;
    int   rr_mode = 1;   // 0: ready high, 1: ready low, 2: random
    int   bd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       result_ready = 1'b1;
            1:       result_ready = 1'b0;
            default: result_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every result handshake.
    logic          bd_exp = 1'b0;
    logic          hold_prev = 1'b0;
    logic [3:0]    held_cls, held_img;
    logic [DW-1:0] held_score;

    always @(negedge clk) begin
        if (reset) begin
            bd_exp    = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("batch_done", 32'(batch_done), 32'(bd_exp));
            if (batch_done) bd_count++;
            if (hold_prev) begin
                check("hold_valid", 32'(result_valid), 32'd1);
                check("hold_class", 32'(result_class), 32'(held_cls));
                check("hold_score", 32'(result_score), 32'(held_score));
                check("hold_image", 32'(result_image), 32'(held_img));
            end
            bd_exp = 1'b0;
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_class", 32'(result_class), 32'(e.cls));
                    check("result_score", 32'(result_score), 32'(e.score));
                    check("result_image", 32'(result_image), 32'(e.img));
                    bd_exp = (32'(e.img) == NI - 1);
                end
            end
            hold_prev  = result_valid && !result_ready;
            held_cls   = result_class;
            held_score = result_score;
            held_img   = result_image;
        end
    end

    task automatic push_expected(input logic [DW-1:0] s[NC]);
        exp_t e;
        int   best = 0;
        for (int k = 1; k < NC; k++)
            if ($signed(s[k]) > $signed(s[best])) best = k;
        e.cls   = 4'(best);
        e.score = s[best];
        e.img   = 4'(model_img);
        sb.push_back(e);
        model_img = (model_img + 1) % NI;
    endtask

    task automatic offer_score(input logic [DW-1:0] v);
        int   n = 0;
        logic ok = 1'b0;
        score_valid = 1'b1;
        score_data  = v;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = score_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("score_accept_timeout", 32'd0, 32'd1);
        score_valid = 1'b0;
    endtask

    task automatic send_image(input logic [DW-1:0] s[NC], input int maxgap);
        push_expected(s);
        for (int k = 0; k < NC; k++) begin
            int gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            offer_score(s[k]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_img = 0;
    endtask

    logic [DW-1:0] img[NC];
    int            vals[NC];

    initial begin
        @(negedge clk);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result_class", 32'(result_class), 32'd0);
        check("rst_result_score", 32'(result_score), 32'd0);
        check("rst_result_image", 32'(result_image), 32'd0);
        check("rst_batch_done", 32'(batch_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_score_ready", 32'(score_ready), 32'd1);
        @(posedge clk);
        #1;
        rr_mode = 0;

        // Directed image with a tie at the maximum.
        vals = '{3, 7, -2, 9, 9, 0, 1, -5, 4, 2};
        for (int k = 0; k < NC; k++) img[k] = DW'(vals[k]);
        send_image(img, 0);
        check("latency_valid", 32'(result_valid), 32'd1);
        check("tie_class", 32'(result_class), 32'd3);
        drain();

        // All scores at the most negative value.
        for (int k = 0; k < NC; k++) img[k] = 16'h8000;
        send_image(img, 0);
        drain();

        // Stall the consumer; offered scores must not be taken meanwhile.
        rr_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NC; k++) img[k] = DW'(k * 3 - 10);
        img[9] = 16'h7FFF;
        send_image(img, 0);
        score_valid = 1'b1;
        score_data  = 16'd100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(result_valid), 32'd1);
            check("stall_score_ready", 32'(score_ready), 32'd0);
            check("stall_class", 32'(result_class), 32'd9);
            check("stall_score", 32'(result_score), 32'h7FFF);
        end
        @(posedge clk);
        #1;
        rr_mode = 0;
        for (int k = 0; k < NC; k++) img[k] = DW'(k);
        img[0] = 16'd100;
        send_image(img, 0);
        drain();

        // Full batch plus one image to see the index wrap and batch_done.
        do_reset();
        bd_count = 0;
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NC; k++) img[k] = DW'($urandom);
            send_image(img, 0);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("batch_done_pulses", 32'(bd_count), 32'd1);
        for (int k = 0; k < NC; k++) img[k] = DW'($urandom);
        send_image(img, 0);
        drain();

        // Reset in the middle of an image discards it.
        for (int k = 0; k < 4; k++) offer_score(DW'(50 + k));
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_spurious_result", 32'(result_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NC; k++) img[k] = DW'(k + 1);
        send_image(img, 0);
        check("post_reset_class", 32'(result_class), 32'd9);
        check("post_reset_image", 32'(result_image), 32'd0);
        drain();

        // Randomized traffic with gaps on both sides.
        rr_mode = 2;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < NC; k++)
                img[k] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 6) - 3) : DW'($urandom);
            send_image(img, 2);
        end
        rr_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
